// File: rtl/serial_feeder_4_if.sv
// Upstream word handshake plus the serial/parallel lines feeding a downstream shift register.
interface serial_feeder_4_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             Din_serie;
    logic             sel;
    logic [WIDTH-1:0] Din;
    logic             done;
    logic             parity;

    modport master (
        output in_valid, in_data,
        input  in_ready, Din_serie, sel, Din, done, parity
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, Din_serie, sel, Din, done, parity
    );
endinterface

// File: rtl/serial_feeder_4.sv
// Serialises parallel words LSB first into a downstream shift register and
// publishes the last completed word and its parity for parallel reload.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for a word; downstream held in parallel-load mode
//   ST_SHIFT | one bit per cycle on Din_serie, sel=1, WIDTH cycles long
//   ST_DONE  | one-cycle done pulse; a new word may be accepted here
module serial_feeder_4 #(
    parameter int WIDTH   = 4,
    parameter bit PAR_ODD = 1'b0
) (
    input logic          clk,
    input logic          reset,
    serial_feeder_4_if.slave bus
);
    localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] din_q;
    logic [CW-1:0]    cnt_q;
    logic             ready_q;
    logic             parity_q;

    logic             accept;
    logic             last_bit;
    logic             sel_c;
    logic             serie_c;
    logic             done_c;

    assign accept   = bus.in_valid & ready_q;
    assign last_bit = (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        sel_c   = 1'b0;
        serie_c = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                sel_c   = 1'b1;
                serie_c = sh_q[0];
                if (last_bit) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_c  = 1'b1;
                state_d = accept ? ST_SHIFT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // in_ready follows the next state so it is already low for the first shift cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_SHIFT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q     <= '0;
            word_q   <= '0;
            cnt_q    <= '0;
            din_q    <= '0;
            parity_q <= 1'b0;
        end else begin
            if (accept) begin
                sh_q   <= bus.in_data;
                word_q <= bus.in_data;
                cnt_q  <= '0;
            end else if (state_q == ST_SHIFT) begin
                sh_q <= sh_q >> 1;
                // hold at the terminal count so the counter never wraps
                if (!last_bit) cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == ST_SHIFT && last_bit) begin
                din_q    <= word_q;
                parity_q <= (^word_q) ^ PAR_ODD;
            end
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.sel       = sel_c;
    assign bus.Din_serie = serie_c;
    assign bus.done      = done_c;
    assign bus.Din       = din_q;
    assign bus.parity    = parity_q;
endmodule

// File: tb/tb_serial_feeder_4.sv
// Directed bench for serial_feeder_4: a 4-bit even-parity instance and an
// 8-bit odd-parity instance, checked every cycle against a transfer-timeline model.
module tb_serial_feeder_4;
    logic clk;
    logic reset;
    int   cyc;
    int   nvec;
    int   nerr;

    serial_feeder_4_if #(.WIDTH(4)) b4 ();
    serial_feeder_4_if #(.WIDTH(8)) b8 ();

    serial_feeder_4 #(.WIDTH(4), .PAR_ODD(1'b0)) dut4 (.clk(clk), .reset(reset), .bus(b4));
    serial_feeder_4 #(.WIDTH(8), .PAR_ODD(1'b1)) dut8 (.clk(clk), .reset(reset), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic        o_rdy[2];
    logic        o_sel[2];
    logic        o_ser[2];
    logic        o_done[2];
    logic        o_par[2];
    logic [15:0] o_din[2];
    logic        v_in[2];
    logic [15:0] d_in[2];

    assign o_rdy[0]  = b4.in_ready;   assign o_rdy[1]  = b8.in_ready;
    assign o_sel[0]  = b4.sel;        assign o_sel[1]  = b8.sel;
    assign o_ser[0]  = b4.Din_serie;  assign o_ser[1]  = b8.Din_serie;
    assign o_done[0] = b4.done;       assign o_done[1] = b8.done;
    assign o_par[0]  = b4.parity;     assign o_par[1]  = b8.parity;
    assign o_din[0]  = {12'd0, b4.Din};
    assign o_din[1]  = {8'd0, b8.Din};
    assign v_in[0]   = b4.in_valid;   assign v_in[1]   = b8.in_valid;
    assign d_in[0]   = {12'd0, b4.in_data};
    assign d_in[1]   = {8'd0, b8.in_data};

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: each instance is described by its position in the transfer timeline.
    // pos 0 = no transfer, 1..W = shifting bit pos-1, W+1 = done cycle.
    int          mw[2];
    bit          mpo[2];
    int          pos[2];
    logic [15:0] mword[2];
    logic [15:0] mlast[2];
    logic        mpar[2];
    logic        mrdy[2];

    initial begin
        mw[0] = 4; mpo[0] = 1'b0;
        mw[1] = 8; mpo[1] = 1'b1;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                pos[i] = 0; mword[i] = '0; mlast[i] = '0; mpar[i] = 1'b0; mrdy[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pos[i] >= 1 && pos[i] < mw[i]) begin
                    pos[i] = pos[i] + 1;
                end else if (pos[i] == mw[i]) begin
                    pos[i]  = mw[i] + 1;
                    mlast[i] = mword[i];
                    mpar[i]  = (^mword[i]) ^ mpo[i];
                end else if (v_in[i] && mrdy[i]) begin
                    mword[i] = d_in[i];
                    pos[i]   = 1;
                end else begin
                    pos[i] = 0;
                end
                mrdy[i] = !(pos[i] >= 1 && pos[i] <= mw[i]);
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic exp_sel;
            exp_sel = (pos[i] >= 1 && pos[i] <= mw[i]);
            chk($sformatf("in_ready[%0d]", i), 16'(o_rdy[i]), 16'(mrdy[i]));
            chk($sformatf("sel[%0d]", i), 16'(o_sel[i]), 16'(exp_sel));
            chk($sformatf("Din_serie[%0d]", i), 16'(o_ser[i]),
                exp_sel ? 16'(mword[i][pos[i]-1]) : 16'd0);
            chk($sformatf("done[%0d]", i), 16'(o_done[i]), 16'(pos[i] == mw[i] + 1));
            chk($sformatf("Din[%0d]", i), o_din[i], mlast[i]);
            chk($sformatf("parity[%0d]", i), 16'(o_par[i]), 16'(mpar[i]));
        end
    end

    // Downstream register fed by the 4-bit instance
    logic [3:0] dsr;
    always @(posedge clk or negedge reset) begin
        if (!reset)      dsr <= 4'd0;
        else if (b4.sel) dsr <= {b4.Din_serie, dsr[3:1]};
        else             dsr <= b4.Din;
    end

    task automatic drive(input int i, input logic v, input logic [15:0] w);
        if (i == 0) begin b4.in_valid = v; b4.in_data = w[3:0]; end
        else        begin b8.in_valid = v; b8.in_data = w[7:0]; end
    endtask

    // Returns at the negedge of the first shift cycle
    task automatic send(input int i, input logic [15:0] w);
        int n;
        @(negedge clk);
        drive(i, 1'b1, w);
        n = 0;
        while (!o_rdy[i] && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            nvec++; nerr++;
            $display("FAIL send_timeout[%0d]: in_ready stayed 0 for %0d cycles, want 1", i, n);
        end
        @(posedge clk);
        @(negedge clk);
        drive(i, 1'b0, w);
    endtask

    task automatic wait_done(input int i, output int t);
        int n;
        n = 0;
        while (!o_done[i] && n < 60) begin @(negedge clk); n++; end
        if (n >= 60) begin
            nvec++; nerr++;
            $display("FAIL done_timeout[%0d]: done stayed 0 for %0d cycles, want 1", i, n);
        end
        t = cyc;
    endtask

    initial begin
        int t1, t2, n8;
        logic [3:0] bits;
        cyc = 0; nvec = 0; nerr = 0;
        reset = 1'b0;
        drive(0, 1'b0, 16'd0);
        drive(1, 1'b0, 16'd0);

        // post-reset
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 16'(b4.in_ready), 16'd1);
        chk("post_rst_sel", 16'(b4.sel), 16'd0);
        chk("post_rst_Din", 16'(b4.Din), 16'd0);
        chk("post_rst_parity", 16'(b4.parity), 16'd0);
        chk("post_rst_done", 16'(b4.done), 16'd0);

        // single word 1011
        send(0, 16'hB);
        for (int k = 0; k < 4; k++) begin
            chk("single_sel", 16'(b4.sel), 16'd1);
            bits[k] = b4.Din_serie;
            @(negedge clk);
        end
        chk("single_serial", 16'(bits), 16'hB);
        chk("single_done", 16'(b4.done), 16'd1);
        chk("single_Din", 16'(b4.Din), 16'hB);
        chk("single_parity", 16'(b4.parity), 16'd1);
        chk("single_dsr", 16'(dsr), 16'hB);
        @(negedge clk);
        chk("single_dsr_reload", 16'(dsr), 16'hB);

        // back-to-back A then 5
        @(negedge clk);
        drive(0, 1'b1, 16'hA);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b1, 16'h5);
        wait_done(0, t1);
        chk("b2b_Din_first", 16'(b4.Din), 16'hA);
        chk("b2b_ready_in_done", 16'(b4.in_ready), 16'd1);
        @(negedge clk);
        drive(0, 1'b0, 16'h5);
        chk("b2b_second_accepted", 16'(b4.sel), 16'd1);
        wait_done(0, t2);
        chk("b2b_done_spacing", 16'(t2 - t1), 16'd5);
        chk("b2b_Din_second", 16'(b4.Din), 16'h5);

        // busy ignore
        repeat (2) @(negedge clk);
        send(0, 16'h3);
        @(negedge clk);
        drive(0, 1'b1, 16'hF);
        @(negedge clk);
        drive(0, 1'b0, 16'h0);
        wait_done(0, t1);
        chk("busy_Din", 16'(b4.Din), 16'h3);
        repeat (2) @(negedge clk);
        chk("busy_no_extra", 16'(b4.sel), 16'd0);

        // mid-shift reset
        send(0, 16'h9);
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_ready", 16'(b4.in_ready), 16'd0);
        chk("rst_sel", 16'(b4.sel), 16'd0);
        chk("rst_serie", 16'(b4.Din_serie), 16'd0);
        chk("rst_done", 16'(b4.done), 16'd0);
        chk("rst_Din", 16'(b4.Din), 16'd0);
        chk("rst_parity", 16'(b4.parity), 16'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", 16'(b4.in_ready), 16'd1);
        chk("rst_release_Din", 16'(b4.Din), 16'd0);
        send(0, 16'h6);
        wait_done(0, t1);
        chk("after_rst_Din", 16'(b4.Din), 16'h6);
        chk("after_rst_parity", 16'(b4.parity), 16'd0);

        // 8-bit odd parity, all zeros
        repeat (2) @(negedge clk);
        send(1, 16'h00);
        n8 = 0;
        t1 = 0;
        while (!b8.done && t1 < 40) begin
            if (b8.sel) n8++;
            @(negedge clk);
            t1++;
        end
        chk("w8_shift_cycles", 16'(n8), 16'd8);
        chk("w8_done", 16'(b8.done), 16'd1);
        chk("w8_parity", 16'(b8.parity), 16'd1);
        chk("w8_Din", 16'(b8.Din), 16'h00);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
